// File: rtl/squash_pipe.sv
// squash_pipe: DEPTH-stage data pipe with per-stage valid bits,
// global stall (en), global squash (squashn) and per-stage kill.
// Ports: clk, resetn (async, active-low), en, squashn, kill_mask,
//   in_valid, d -> q, out_valid (stage DEPTH-1), occupancy, empty.
module squash_pipe #(
  parameter int              WIDTH    = 32,
  parameter int              DEPTH    = 3,
  parameter logic [WIDTH-1:0] RESETVAL = '0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       en,
  input  logic                       squashn,
  input  logic [DEPTH-1:0]           kill_mask,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       empty
);

  localparam int OW = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("squash_pipe: DEPTH must be >= 1");
  end

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] ev;
  logic [DEPTH-1:0] nxt_v;
  logic             adv;

  assign ev  = v & ~kill_mask;
  assign adv = squashn & en;

  // Incoming entry is never killed; a kill on the last
  // stage during an advance only drops the leaving entry.
  always_comb begin
    nxt_v = v;
    if (!squashn) begin
      nxt_v = '0;
    end else if (en) begin
      nxt_v[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        nxt_v[i] = ev[i-1];
      end
    end else begin
      nxt_v = ev;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v <= '0;
    end else begin
      v <= nxt_v;
    end
  end

  // Data moves on every advance, valid or not; squash
  // leaves data untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= RESETVAL;
      end
    end else if (adv) begin
      data[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        data[i] <= data[i-1];
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OW'(v[i]);
    end
  end

  assign q         = data[DEPTH-1];
  assign out_valid = v[DEPTH-1];
  assign empty     = (occupancy == '0);

endmodule

// File: tb/tb_squash_pipe.sv
// tb_squash_pipe: directed vector table, async reset sequence
// and random stimulus against a queue-based reference model.
module tb_squash_pipe;

  localparam int W  = 32;
  localparam int D  = 3;
  localparam int OW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          en = 1'b0;
  logic          squashn = 1'b1;
  logic [D-1:0]  kill_mask = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  d = '0;
  logic [W-1:0]  q;
  logic          out_valid;
  logic [OW-1:0] occupancy;
  logic          empty;

  squash_pipe #(
    .WIDTH(W),
    .DEPTH(D),
    .RESETVAL('0)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .en(en),
    .squashn(squashn),
    .kill_mask(kill_mask),
    .in_valid(in_valid),
    .d(d),
    .q(q),
    .out_valid(out_valid),
    .occupancy(occupancy),
    .empty(empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [W-1:0] act,
                     logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [W-1:0] eq,
                         logic eov, logic [OW-1:0] eocc);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".out_valid"}, W'(out_valid), W'(eov));
    chk({tag, ".occ"}, W'(occupancy), W'(eocc));
    chk({tag, ".empty"}, W'(empty), W'(eocc == 0));
  endtask

  typedef struct {
    logic          en;
    logic          sq;
    logic [D-1:0]  km;
    logic          iv;
    logic [W-1:0]  d;
    logic [W-1:0]  q;
    logic          ov;
    logic [OW-1:0] occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic s, logic [D-1:0] k,
                              logic i, logic [W-1:0] dd,
                              logic [W-1:0] eq, logic eov,
                              logic [OW-1:0] eo);
    vec_t r;
    r.en = e; r.sq = s; r.km = k; r.iv = i; r.d = dd;
    r.q = eq; r.ov = eov; r.occ = eo;
    return r;
  endfunction

  typedef struct {
    logic         vld;
    logic [W-1:0] dat;
  } ent_t;

  ent_t mq[$];

  task automatic drive(logic e, logic s, logic [D-1:0] k,
                       logic i, logic [W-1:0] dd);
    en = e; squashn = s; kill_mask = k; in_valid = i; d = dd;
  endtask

  localparam logic [W-1:0] A  = 32'hA5A5_0001;
  localparam logic [W-1:0] B  = 32'hA5A5_0002;
  localparam logic [W-1:0] C  = 32'hA5A5_0003;
  localparam logic [W-1:0] DD = 32'hA5A5_0004;

  initial begin
    // latency: first word visible two edges after capture
    tbl.push_back(mk(1, 1, 3'b000, 1, A,  0, 0, 1));
    tbl.push_back(mk(1, 1, 3'b000, 1, B,  0, 0, 2));
    tbl.push_back(mk(1, 1, 3'b000, 1, C,  A, 1, 3));
    tbl.push_back(mk(1, 1, 3'b000, 1, DD, B, 1, 3));
    // stall five cycles with in_valid high: nothing moves
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 3'b000, 1, 32'hFFFF, B, 1, 3));
    // drain in order; data keeps loading on bubbles
    tbl.push_back(mk(1, 1, 3'b000, 0, 32'h11, C,  1, 2));
    tbl.push_back(mk(1, 1, 3'b000, 0, 32'h22, DD, 1, 1));
    tbl.push_back(mk(1, 1, 3'b000, 0, 32'h33, 32'h11, 0, 0));
    // refill
    tbl.push_back(mk(1, 1, 3'b000, 1, 32'hE1, 32'h22, 0, 1));
    tbl.push_back(mk(1, 1, 3'b000, 1, 32'hE2, 32'h33, 0, 2));
    tbl.push_back(mk(1, 1, 3'b000, 1, 32'hE3, 32'hE1, 1, 3));
    // squash beats en and in_valid; data holds
    tbl.push_back(mk(1, 0, 3'b111, 1, 32'hF0, 32'hE1, 0, 0));
    tbl.push_back(mk(1, 1, 3'b000, 1, 32'hE4, 32'hE2, 0, 1));
    tbl.push_back(mk(1, 1, 3'b000, 1, 32'hE5, 32'hE3, 0, 2));
    tbl.push_back(mk(1, 1, 3'b000, 1, 32'hE6, 32'hE4, 1, 3));
    // selective kill on stall, bubble exits next cycle
    tbl.push_back(mk(0, 1, 3'b010, 0, 32'h70, 32'hE4, 1, 2));
    tbl.push_back(mk(1, 1, 3'b000, 0, 32'h77, 32'hE5, 0, 1));
    tbl.push_back(mk(1, 1, 3'b000, 0, 32'h78, 32'hE6, 1, 1));
    // kill on the last stage while advancing
    tbl.push_back(mk(1, 1, 3'b100, 0, 32'h79, 32'h77, 0, 0));
    // kill never touches the incoming entry
    tbl.push_back(mk(1, 1, 3'b001, 1, 32'h80, 32'h78, 0, 1));
    tbl.push_back(mk(0, 1, 3'b001, 0, 32'h81, 32'h78, 0, 0));

    // reset state, then release with en low
    #12;
    chk_all("reset", '0, 0, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk_all("post_reset_idle", '0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].sq, tbl[i].km, tbl[i].iv, tbl[i].d);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].ov, tbl[i].occ);
    end

    // async reset between edges with two entries in flight
    drive(1, 1, '0, 1, 32'hC1);
    @(posedge clk); #1;
    drive(1, 1, '0, 1, 32'hC2);
    @(posedge clk); #1;
    chk("async.pre_occ", W'(occupancy), 2);
    drive(0, 1, '0, 0, '0);
    #3 resetn = 1'b0;
    #1;
    chk_all("async_reset", '0, 0, 0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    chk_all("async_release", '0, 0, 0);

    // random phase against the queue model
    mq.delete();
    for (int i = 0; i < D; i++) mq.push_back('{1'b0, '0});
    for (int n = 0; n < 600; n++) begin
      logic          e, s, iv;
      logic [D-1:0]  k;
      logic [W-1:0]  dd;
      int            cnt;
      e  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 15) != 0);
      iv = ($urandom_range(0, 3) != 0);
      k  = ($urandom_range(0, 3) == 0) ? D'($urandom) : '0;
      dd = $urandom;
      drive(e, s, k, iv, dd);
      if (!s) begin
        foreach (mq[j]) mq[j].vld = 1'b0;
      end else if (e) begin
        foreach (mq[j]) if (k[j]) mq[j].vld = 1'b0;
        void'(mq.pop_back());
        mq.push_front('{iv, dd});
      end else begin
        foreach (mq[j]) if (k[j]) mq[j].vld = 1'b0;
      end
      cnt = 0;
      foreach (mq[j]) cnt += int'(mq[j].vld);
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", n), mq[D-1].dat, mq[D-1].vld,
              OW'(cnt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/squash_pipe.md
Name: squash_pipe

Overview:
- Parametrised multi-stage pipeline register with per-stage valid bits, global stall, global squash and selective per-stage kill.
- Next-generation replacement for the single-stage enable/squash register in the soft-processor datapath (e.g. the hi/lo result path and multi-cycle unit staging).
- Carries WIDTH-bit data through DEPTH stages and reports occupancy, so control logic can drain or flush in-flight results.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 3, number of pipeline stages. Legal range: DEPTH >= 1. Values below 1 are a synthesis-time error.
- RESETVAL, 0, value loaded into every data stage on reset.

Ports:
- clk, input, 1, clock, rising edge.
- resetn, input, 1, asynchronous active-low reset.
- en, input, 1, advance enable. 1 = shift one stage; 0 = stall/hold.
- squashn, input, 1, active-low global squash. Kills all in-flight entries and the incoming entry.
- kill_mask, input, DEPTH, active-high selective kill. Bit i kills the entry currently held in stage i.
- in_valid, input, 1, qualifies d.
- d, input, WIDTH, data into stage 0.
- q, output, WIDTH, data of stage DEPTH-1.
- out_valid, output, 1, valid bit of stage DEPTH-1.
- occupancy, output, $clog2(DEPTH+1), number of valid stages.
- empty, output, 1, high when occupancy == 0.

Behaviour:
- Reset
  - Clock: clk. Reset: resetn, asynchronous, active-low.
  - While resetn = 0: all data stages = RESETVAL, all valid bits = 0.
  - Therefore q = RESETVAL, out_valid = 0, occupancy = 0, empty = 1.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- State per stage i: data[i] (WIDTH bits) and v[i] (1 bit).
- Effective valid: ev[i] = v[i] & ~kill_mask[i].
- Priority at each rising edge, highest first:
  1. squashn = 0: all v <= 0, independent of en, in_valid and kill_mask. Data registers hold (no write).
  2. en = 1 (squashn = 1), shift:
     - v[0] <= in_valid; data[0] <= d.
     - For i >= 1: v[i] <= ev[i-1]; data[i] <= data[i-1].
     - The entry in stage DEPTH-1 leaves the pipe, killed or not.
  3. en = 0 (squashn = 1), stall: v[i] <= ev[i]. Data holds.
- Data stages load on every advancing edge, valid or not. Downstream logic must qualify q with out_valid.
- kill_mask never affects the incoming in_valid/d. Killing an entry in the same cycle it enters needs squashn.
- Outputs
  - q = data[DEPTH-1]; out_valid = v[DEPTH-1]. Both registered, no combinational path from inputs.
  - occupancy = popcount(v), combinational from registers only. empty = (occupancy == 0).
- Latency: an entry accepted at edge N with en held high appears on q/out_valid after edge N+DEPTH-1, i.e. visible in cycle N+DEPTH-1.
- Each low cycle of en adds one cycle of latency.
- Boundaries
  - Full pipe with en = 1 and in_valid = 1: occupancy stays DEPTH. There is no back-pressure; an entry is lost only through squash or kill.
  - Full pipe with en = 0: all entries hold indefinitely.
  - DEPTH = 1: behaves as a single enable/squash register plus a valid bit. kill_mask[0] clears v[0] on a stall edge and, on an advance edge, affects only the outgoing entry.
  - squashn = 0 and en = 1 together: squash wins. The pipe is empty next cycle and d is not captured.

Test Plan:
- Reset/idle: hold resetn = 0, RESETVAL = 0 -> q = 0, out_valid = 0, occupancy = 0, empty = 1. Release reset with en = 0 -> no change.
- Latency (DEPTH = 3): en = 1, inject d = 0xA5A5_0001, 0x...02, 0x...03 back-to-back -> first word on q with out_valid = 1 two edges after capture, then one word per cycle. occupancy sequence 1, 2, 3, 3.
- Stall: fill 3 entries, hold en = 0 for 5 cycles -> q and occupancy = 3 constant. Raise en -> drain in original order.
- Global squash: full pipe, pulse squashn = 0 with en = 1 and in_valid = 1 -> next cycle occupancy = 0, out_valid = 0, q unchanged.
- Selective kill: full pipe, en = 0, kill_mask = 3'b010 -> occupancy 3 -> 2, stage 1 invalid. Then en = 1 with kill_mask = 0 -> bubble reaches out_valid = 0 exactly one cycle later.
- Async reset mid-stream: assert resetn = 0 between clock edges with occupancy = 2 -> outputs return to reset values immediately, before the next clk edge.
